mode_counter: RTL and testbench

Parameterised prescaled up/down counter with programmable terminal limit, free-run / modulo / one-shot modes, a terminal-count pulse and an optional compare-match pulse. It generalises the core's primitive counters into a timer-grade cell for CSR timers, performance counters and pipeline timeout logic. All outputs are registered; one clock domain.

---
 rtl/mode_counter.sv | 144 ++++++++++++++
 tb/tb_mode_counter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
// mode_counter: prescaled up/down counter with free-run, modulo and one-shot modes.
// Ports: clk, rst_n, en, up, mode[1:0], load, load_data, limit, presc, cmp_val -> count, tc, cmp_match, done.
// Optional macro MODE_COUNTER_CMP_EN builds the compare-match logic; otherwise cmp_match is tied to 0.
module mode_counter #(
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               up,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_data,
    input  logic [WIDTH-1:0]   limit,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   cmp_val,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               cmp_match,
    output logic               done
);

    typedef enum logic [1:0] {
        MODE_FREE = 2'b00,
        MODE_MOD  = 2'b01,
        MODE_ONE  = 2'b10,
        MODE_RSV  = 2'b11
    } mode_e;

    logic [PRESC_W-1:0] psc_q, psc_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               tc_q, tc_d;
    logic               done_q, done_d;
    logic               cmp_q, cmp_d;

    logic  tick;
    logic  terminal;
    logic  is_mod;
    logic  is_one;
    logic  wr;
    mode_e mode_s;

    assign mode_s = mode_e'(mode);
    assign is_mod = (mode_s == MODE_MOD);
    assign is_one = (mode_s == MODE_ONE);

    // Prescaler match; a presc lowered below psc wraps through 2^PRESC_W.
    assign tick = en && (psc_q == presc);

    // Modes 01/10 use >= so a load above limit terminates on the first tick.
    always_comb begin
        terminal = 1'b0;
        if (up) begin
            if (is_mod || is_one) begin
                terminal = (count_q >= limit);
            end else begin
                terminal = (count_q == {WIDTH{1'b1}});
            end
        end else begin
            terminal = (count_q == '0);
        end
    end

    always_comb begin
        psc_d   = psc_q;
        count_d = count_q;
        done_d  = done_q;
        tc_d    = 1'b0;
        wr      = 1'b0;
        if (load) begin
            count_d = load_data;
            psc_d   = '0;
            done_d  = 1'b0;
        end else if (en) begin
            if (tick) begin
                psc_d = '0;
                // An expired one-shot ignores ticks until reloaded.
                if (!done_q) begin
                    if (terminal) begin
                        tc_d = 1'b1;
                        unique case (1'b1)
                            is_one: begin
                                done_d = 1'b1;
                            end
                            is_mod: begin
                                count_d = up ? '0 : limit;
                                wr      = 1'b1;
                            end
                            default: begin
                                count_d = up ? '0 : {WIDTH{1'b1}};
                                wr      = 1'b1;
                            end
                        endcase
                    end else begin
                        if (up) begin
                            count_d = count_q + WIDTH'(1);
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                        wr = 1'b1;
                    end
                end
            end else begin
                psc_d = psc_q + PRESC_W'(1);
            end
        end
    end

`ifdef MODE_COUNTER_CMP_EN
    // Only a tick that writes count can raise the compare pulse.
    always_comb begin
        cmp_d = wr && (count_d == cmp_val);
    end
`else
    logic unused_cmp;
    assign unused_cmp = ^{cmp_val, wr};
    always_comb begin
        cmp_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q   <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            cmp_q   <= 1'b0;
        end else begin
            psc_q   <= psc_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            cmp_q   <= cmp_d;
        end
    end

    assign count     = count_q;
    assign tc        = tc_q;
    assign done      = done_q;
    assign cmp_match = cmp_q;

endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: randomized and directed checks of mode_counter
// against a cycle-level arithmetic reference model.
module tb_mode_counter;

    localparam int W  = 8;
    localparam int PW = 4;
    localparam int CMAX = (1 << W) - 1;

`ifdef MODE_COUNTER_CMP_EN
    localparam bit CMP_ON = 1'b1;
`else
    localparam bit CMP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          up = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic          load = 1'b0;
    logic [W-1:0]  load_data = '0;
    logic [W-1:0]  limit = '0;
    logic [PW-1:0] presc = '0;
    logic [W-1:0]  cmp_val = '0;
    logic [W-1:0]  count;
    logic          tc;
    logic          cmp_match;
    logic          done;

    int checks = 0;
    int failures = 0;

    int m_cnt = 0;
    int m_psc = 0;
    bit m_tc = 0;
    bit m_cm = 0;
    bit m_done = 0;

    mode_counter #(.WIDTH(W), .PRESC_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .mode(mode),
        .load(load), .load_data(load_data), .limit(limit),
        .presc(presc), .cmp_val(cmp_val), .count(count), .tc(tc),
        .cmp_match(cmp_match), .done(done)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_cnt = 0; m_psc = 0; m_tc = 0; m_cm = 0; m_done = 0;
    endtask

    // One rising edge of the reference behaviour using current inputs.
    task automatic model_edge();
        bit term;
        bit wr;
        int lim;
        m_tc = 0;
        m_cm = 0;
        if (load) begin
            m_cnt = int'(load_data); m_psc = 0; m_done = 0;
            return;
        end
        if (!en) return;
        if (m_psc != int'(presc)) begin
            m_psc = (m_psc + 1) % (1 << PW);
            return;
        end
        m_psc = 0;
        if (m_done) return;
        lim = (mode == 2'd1 || mode == 2'd2) ? int'(limit) : CMAX;
        term = up ? (m_cnt >= lim) : (m_cnt == 0);
        wr = 1;
        if (!term) begin
            m_cnt = up ? (m_cnt + 1) % (CMAX + 1) : (m_cnt + CMAX) % (CMAX + 1);
        end else begin
            m_tc = 1;
            if (mode == 2'd2) begin
                m_done = 1; wr = 0;
            end else if (mode == 2'd1) begin
                m_cnt = up ? 0 : int'(limit);
            end else begin
                m_cnt = up ? 0 : CMAX;
            end
        end
        if (wr && CMP_ON && m_cnt == int'(cmp_val)) m_cm = 1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({count, tc, cmp_match, done} !== {W'(0), 3'b000}) begin
            failures++;
            $display("FAIL reset_init got=%h/%b%b%b exp=0/000", count, tc, cmp_match, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        step();
        en = 1'b1; presc = '0; mode = 2'b00; up = 1'b1;
        repeat (5) step();
        checks++;
        if (count !== W'(5)) begin
            failures++;
            $display("FAIL reset_precount got=%0d exp=5", count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({count, tc, cmp_match, done} !== {W'(0), 3'b000}) begin
            failures++;
            $display("FAIL reset_mid got=%h/%b%b%b exp=0/000", count, tc, cmp_match, done);
        end
        model_clear();
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_prescale();
        presc = 4'd3; en = 1'b1; mode = 2'b00; up = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++;
            if (count !== W'(k / 4) || tc !== 1'b0 || count !== W'(m_cnt)) begin
                failures++;
                $display("FAIL prescale k=%0d got=%0d tc=%b exp=%0d", k, count, tc, k / 4);
            end
        end
    endtask

    task automatic test_modulo();
        load = 1'b1; load_data = '0; step(); load = 1'b0;
        mode = 2'b01; limit = W'(9); presc = '0; up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (count !== W'(k % 10) || tc !== (k % 10 == 0)) begin
                failures++;
                $display("FAIL modulo_up k=%0d got=%0d tc=%b exp=%0d", k, count, tc, k % 10);
            end
        end
        load = 1'b1; load_data = '0; step(); load = 1'b0; up = 1'b0;
        step();
        checks++;
        if (count !== W'(9) || tc !== 1'b1) begin
            failures++;
            $display("FAIL modulo_down got=%0d tc=%b exp=9 tc=1", count, tc);
        end
        up = 1'b1;
    endtask

    task automatic test_oneshot();
        logic [W-1:0] ec;
        load = 1'b1; load_data = '0; step(); load = 1'b0;
        mode = 2'b10; limit = W'(3); presc = '0; up = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            ec = (k <= 3) ? W'(k) : W'(3);
            checks++;
            if (count !== ec || tc !== (k == 4) || done !== (k >= 4)) begin
                failures++;
                $display("FAIL oneshot k=%0d got=%0d tc=%b done=%b exp=%0d", k, count, tc, done, ec);
            end
        end
        load = 1'b1; load_data = '0; step(); load = 1'b0;
        checks++;
        if (done !== 1'b0 || count !== W'(0)) begin
            failures++;
            $display("FAIL oneshot_reload done=%b count=%0d exp done=0 count=0", done, count);
        end
    endtask

    task automatic test_compare();
        mode = 2'b00; up = 1'b1; presc = '0; cmp_val = W'(7);
        load = 1'b1; load_data = '0; step(); load = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (cmp_match !== (CMP_ON && k == 7) || count !== W'(k)) begin
                failures++;
                $display("FAIL compare k=%0d got cmp=%b count=%0d exp cmp=%b", k, cmp_match, count, CMP_ON && k == 7);
            end
        end
        load = 1'b1; load_data = W'(7); step(); load = 1'b0;
        checks++;
        if (cmp_match !== 1'b0 || count !== W'(7)) begin
            failures++;
            $display("FAIL compare_load got cmp=%b count=%0d exp cmp=0 count=7", cmp_match, count);
        end
    endtask

    task automatic test_collision();
        mode = 2'b00; up = 1'b1; presc = 4'd3;
        load = 1'b1; load_data = '0; step(); load = 1'b0;
        repeat (3) step();
        load = 1'b1; load_data = W'(20); step(); load = 1'b0;
        checks++;
        if (count !== W'(20) || tc !== 1'b0) begin
            failures++;
            $display("FAIL collision_load got=%0d tc=%b exp=20 tc=0", count, tc);
        end
        repeat (3) step();
        checks++;
        if (count !== W'(20)) begin
            failures++;
            $display("FAIL collision_hold got=%0d exp=20", count);
        end
        step();
        checks++;
        if (count !== W'(21)) begin
            failures++;
            $display("FAIL collision_tick got=%0d exp=21", count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            up = ($urandom_range(0, 3) != 0) ? up : ~up;
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) presc = PW'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) limit = W'($urandom_range(0, 20));
            cmp_val = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 20)) : W'(CMAX);
            load = ($urandom_range(0, 39) == 0);
            load_data = ($urandom_range(0, 3) == 0) ? W'($urandom_range(CMAX - 3, CMAX))
                                                    : W'($urandom_range(0, 24));
            step();
            checks++;
            if ({count, tc, cmp_match, done} !== {W'(m_cnt), m_tc, m_cm, m_done}) begin
                failures++;
                $display("FAIL random i=%0d got=%0d/%b%b%b exp=%0d/%b%b%b", i,
                         count, tc, cmp_match, done, m_cnt, m_tc, m_cm, m_done);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_modulo();
        test_oneshot();
        test_compare();
        test_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
